// File: rtl/cam_capture_rgb332.sv
`default_nettype none
// ============================================================================
//  Module   : cam_capture_rgb332
//  Brief    : Captures RGB565 camera frames (two bytes per pixel, high byte
//             first) and writes them to a frame buffer as RGB332 pixels,
//             one write per pixel, in single-shot or continuous mode.
//  Revision : 1.0 - initial release
// ============================================================================
module cam_capture_rgb332 #(
    parameter int AW    = 15,   // frame-buffer address width
    parameter int DW    = 8,    // frame-buffer pixel width (RGB332)
    parameter int IMG_W = 160,  // pixels per line
    parameter int IMG_H = 120   // lines per frame
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          cont,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow
);

    // One bit wider than the address so the counter can hold the full pixel
    // count even when IMG_W*IMG_H == 2**AW.
    localparam logic [AW:0] c_NUM_PIX = (AW+1)'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_VS   = 2'd1,
        S_WAIT_FALL = 2'd2,
        S_CAPTURE   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_vs_d;
    logic            r_phase;     // 0: expecting high byte, 1: expecting low byte
    logic [2:0]      r_red;       // R[2:0] taken from the high byte
    logic [2:0]      r_grn;       // G[2:0] taken from the high byte
    logic [AW:0]     r_pix_cnt;   // pixels written in the current frame

    logic            w_vs_rise;
    logic            w_vs_fall;
    logic [DW-1:0]   w_pixel;

    assign w_vs_rise = vsync & ~r_vs_d;
    assign w_vs_fall = ~vsync & r_vs_d;

    // Low byte completes the pixel: keep the top two blue bits.
    assign w_pixel = DW'({r_red, r_grn, px_data[4:3]});

    // frame_done must coincide with the vsync rise itself, so it is decoded
    // from the live edge rather than registered.
    assign frame_done = (r_state == S_CAPTURE) && w_vs_rise;
    assign busy       = (r_state != S_IDLE);

    // Delay vsync by one clock for edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
        end else begin
            r_vs_d <= vsync;
        end
    end

    // Capture state machine with byte pairing, pixel counting and the
    // registered frame-buffer write port.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_red       <= 3'd0;
            r_grn       <= 3'd0;
            r_pix_cnt   <= '0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            px_wr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_phase <= 1'b0;
                    if (init) begin
                        r_state <= S_WAIT_VS;
                    end
                end

                S_WAIT_VS: begin
                    r_phase <= 1'b0;
                    if (w_vs_rise) begin
                        r_state <= S_WAIT_FALL;
                    end
                end

                S_WAIT_FALL: begin
                    r_phase <= 1'b0;
                    if (w_vs_fall) begin
                        r_state   <= S_CAPTURE;
                        r_pix_cnt <= '0;
                        overflow  <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    if (!href) begin
                        // A dangling high byte at line end is simply dropped.
                        r_phase <= 1'b0;
                    end else begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_red <= px_data[7:5];
                            r_grn <= px_data[2:0];
                        end else if (r_pix_cnt < c_NUM_PIX) begin
                            px_wr       <= 1'b1;
                            mem_px_data <= w_pixel;
                            mem_px_addr <= r_pix_cnt[AW-1:0];
                            r_pix_cnt   <= r_pix_cnt + 1'b1;
                        end else begin
                            // Frame longer than the buffer: hold count, flag it.
                            overflow <= 1'b1;
                        end
                    end

                    // A low byte arriving with the vsync rise is still
                    // written above; only the state moves on.
                    if (w_vs_rise) begin
                        r_state <= cont ? S_WAIT_FALL : S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cam_capture_rgb332.md
CAM_CAPTURE_RGB332 -- requirements
Module: cam_capture_rgb332

Interface
REQ-001 Parameter AW, default 15, meaning frame-buffer address width.
REQ-002 Parameter DW, default 8, meaning frame-buffer pixel width (RGB332).
REQ-003 Parameter IMG_W, default 160, meaning pixels per line.
REQ-004 Parameter IMG_H, default 120, meaning lines per frame; IMG_W*IMG_H SHALL be <= 2**AW.
REQ-005 pclk  input  1  camera pixel clock; sole clock of the block; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 init  input  1  capture request, sampled each cycle while in IDLE.
REQ-008 cont  input  1  1 = capture frames continuously, 0 = capture one frame.
REQ-009 vsync  input  1  camera frame sync; high = vertical blanking.
REQ-010 href  input  1  camera line valid; high = data bytes valid.
REQ-011 px_data  input  8  camera byte, RGB565, high byte first.
REQ-012 mem_px_addr  output  AW  write address to the frame buffer.
REQ-013 mem_px_data  output  DW  RGB332 pixel to the frame buffer.
REQ-014 px_wr  output  1  frame-buffer write enable, one cycle per pixel.
REQ-015 frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 overflow  output  1  sticky flag: a pixel arrived after IMG_W*IMG_H pixels in the current frame.

Function
REQ-018 vsync SHALL be registered once (vs_d); vsync rise = vsync & ~vs_d, vsync fall = ~vsync & vs_d.
REQ-019 FSM states: IDLE, WAIT_VS, WAIT_FALL, CAPTURE.
REQ-020 IDLE -> WAIT_VS when init=1; WAIT_VS -> WAIT_FALL on vsync rise; WAIT_FALL -> CAPTURE on vsync fall, clearing pixel counter and overflow.
REQ-021 CAPTURE on vsync rise: frame_done=1 for that cycle; next state WAIT_FALL if cont=1, else IDLE.
REQ-022 A byte-phase bit SHALL be cleared whenever href=0 and SHALL toggle on every cycle in CAPTURE with href=1.
REQ-023 Phase 0 byte: store R=px_data[7:5], G=px_data[2:0].
REQ-024 Phase 1 byte: pixel = {R, G, px_data[4:3]}; on the next cycle px_wr=1, mem_px_data=pixel, mem_px_addr=pixel counter value.
REQ-025 Pixel counter SHALL increment by 1 after each write; latency from phase-1 byte to px_wr is exactly 1 cycle.
REQ-026 When the counter equals IMG_W*IMG_H, further completed pixels SHALL NOT write, counter SHALL hold, overflow SHALL set.
REQ-027 href going low after a phase-0 byte SHALL discard that half pixel (no write).
REQ-028 A phase-1 byte coinciding with vsync rise SHALL still be written on the following cycle, and frame_done SHALL pulse in the same cycle as the vsync rise.
REQ-029 px_wr SHALL be 0 in every state except the cycle following a phase-1 byte accepted in CAPTURE.
REQ-030 init asserted outside IDLE SHALL be ignored.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, busy=0, overflow=0, phase=0, vs_d=0.
REQ-032 Reset asserted mid-frame SHALL abort the capture with no further writes; after release the block SHALL wait in IDLE for init.

Verification
REQ-033 Reset then init=1, one 160x120 frame of byte pairs 0xE0,0x1F -> 19200 writes, addresses 0..19199 in order, each mem_px_data=0xE3, one frame_done, return to IDLE.
REQ-034 Bytes 0xF8,0x00 then 0x07,0xE0 then 0x00,0x18 -> mem_px_data 0xE0, 0x1C, 0x03 at addresses 0,1,2.
REQ-035 Line of 5 bytes then href=0 -> exactly 2 writes; fifth byte discarded, next line starts at phase 0.
REQ-036 Frame with 121 lines of 160 pixels -> 19200 writes, overflow=1, mem_px_addr never exceeds 19199.
REQ-037 cont=1, three frames -> three frame_done pulses, address restarts at 0 each frame, busy stays 1.
REQ-038 rst_n=0 for 1 cycle at pixel 500 -> px_wr=0 from reset onward, busy=0, no writes until new init and vsync sequence.
